// File: rtl/bcd_count_sequencer.sv
// Digit-serial N-digit BCD event counter streaming each new count MSD first.
// Define BCD_SEQ_ASCII_EN for 8-bit ASCII digits with leading-zero blanking.
module bcd_count_sequencer #(
    parameter int DIGITS   = 3,
    parameter int PEND_MAX = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                inc_pulse,
    input  logic                clr,
    output logic [4*DIGITS-1:0] bcd_value,
    output logic                busy,
    output logic                wrap,
    output logic                ovf,
    output logic                upd_valid,
    input  logic                upd_ready,
`ifdef BCD_SEQ_ASCII_EN
    output logic [7:0]          upd_digit,
`else
    output logic [3:0]          upd_digit,
`endif
    output logic [2:0]          upd_idx,
    output logic                upd_last
);

    localparam int PW = (PEND_MAX < 2) ? 1 : $clog2(PEND_MAX + 1);
    localparam logic [2:0] LAST = 3'(DIGITS - 1);
    localparam logic [PW-1:0] PFULL = PW'(PEND_MAX);

    typedef enum logic [1:0] {
        IDLE,
        INC,
        SEND
    } state_t;

    state_t              state_q, state_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic [2:0]          k_q, k_d;
    logic [2:0]          j_q, j_d;
    logic [PW-1:0]       pend_q, pend_d;
    logic                ovf_q, ovf_d;
    logic [3:0]          dig_k, dig_j;
    logic                take, wrap_c;
    logic                inc_acc, pend_nz, pend_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bcd_q   <= '0;
            k_q     <= '0;
            j_q     <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            k_q     <= k_d;
            j_q     <= j_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        dig_k = '0;
        dig_j = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (k_q == 3'(i)) dig_k = bcd_q[4*i +: 4];
            if (j_q == 3'(i)) dig_j = bcd_q[4*i +: 4];
        end
    end

    assign pend_nz   = (pend_q != '0);
    assign pend_full = (pend_q == PFULL);

    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        k_d     = k_q;
        j_d     = j_q;
        take    = 1'b0;
        wrap_c  = 1'b0;
        if (clr) begin
            state_d = IDLE;
            bcd_d   = '0;
            k_d     = '0;
            j_d     = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pend_nz) begin
                        take    = 1'b1;
                        k_d     = '0;
                        state_d = INC;
                    end
                end
                INC: begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (k_q == 3'(i)) begin
                            bcd_d[4*i +: 4] = (dig_k == 4'd9) ? 4'd0 : dig_k + 4'd1;
                        end
                    end
                    if (dig_k != 4'd9) begin
                        state_d = SEND;
                        j_d     = LAST;
                    end else if (k_q == LAST) begin
                        wrap_c  = 1'b1;
                        state_d = SEND;
                        j_d     = LAST;
                    end else begin
                        k_d = k_q + 3'd1;
                    end
                end
                SEND: begin
                    if (upd_ready) begin
                        if (j_q == 3'd0) begin
                            // Chain straight into the next increment when work is queued
                            if (pend_nz) begin
                                take    = 1'b1;
                                k_d     = '0;
                                state_d = INC;
                            end else begin
                                state_d = IDLE;
                            end
                        end else begin
                            j_d = j_q - 3'd1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign inc_acc = inc_pulse && !clr;

    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q;
        unique case (1'b1)
            clr: begin
                pend_d = '0;
                ovf_d  = 1'b0;
            end
            (inc_acc && !take && pend_full): ovf_d = 1'b1;
            (inc_acc && !take && !pend_full): pend_d = pend_q + 1'b1;
            (!clr && !inc_acc && take): pend_d = pend_q - 1'b1;
            default: ;
        endcase
    end

    assign bcd_value = bcd_q;
    assign busy      = (state_q != IDLE);
    assign wrap      = wrap_c;
    assign ovf       = ovf_q;
    assign upd_valid = (state_q == SEND);
    assign upd_idx   = upd_valid ? j_q : 3'd0;
    assign upd_last  = upd_valid && (j_q == 3'd0);

`ifdef BCD_SEQ_ASCII_EN
    logic hi_zero;

    always_comb begin
        hi_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (3'(i) > j_q && bcd_q[4*i +: 4] != 4'd0) hi_zero = 1'b0;
        end
    end

    always_comb begin
        upd_digit = 8'h00;
        if (upd_valid) begin
            if (hi_zero && dig_j == 4'd0 && j_q != 3'd0) upd_digit = 8'h20;
            else upd_digit = {4'h3, dig_j};
        end
    end
`else
    assign upd_digit = upd_valid ? dig_j : 4'd0;
`endif

endmodule

// File: tb/tb_bcd_count_sequencer.sv
// Randomized self-checking bench for bcd_count_sequencer.
// Expected streams come from an integer count model.
module tb_bcd_count_sequencer;

    localparam int DIGITS = 3;
`ifdef BCD_SEQ_ASCII_EN
    localparam int DW = 8;
`else
    localparam int DW = 4;
`endif

    typedef struct packed {
        logic [DW-1:0] d;
        logic [2:0]    i;
        logic          l;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic inc_pulse = 1'b0;
    logic clr = 1'b0;
    logic upd_ready = 1'b0;
    logic [4*DIGITS-1:0] bcd_value;
    logic busy, wrap, ovf, upd_valid, upd_last;
    logic [DW-1:0] upd_digit;
    logic [2:0] upd_idx;

    int tests = 0;
    int fails = 0;
    int inc_cyc, wrap_cnt, wrap_bad, stall_bad;
    beat_t beats[$];
    bit stall_pend = 0;
    beat_t prev;

    bcd_count_sequencer #(.DIGITS(DIGITS), .PEND_MAX(15)) dut (
        .clk(clk), .rst_n(rst_n), .inc_pulse(inc_pulse), .clr(clr),
        .bcd_value(bcd_value), .busy(busy), .wrap(wrap), .ovf(ovf),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_digit(upd_digit),
        .upd_idx(upd_idx), .upd_last(upd_last)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] exp_digit(input int v, input int j);
        int p = 1;
        int d;
        for (int n = 0; n < j; n++) p = p * 10;
        d = (v / p) % 10;
`ifdef BCD_SEQ_ASCII_EN
        if (j != 0 && v < p) return 8'h20;
        return 8'h30 + DW'(d);
`else
        return DW'(d);
`endif
    endfunction

    function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
        logic [4*DIGITS-1:0] r = '0;
        int t = v;
        for (int n = 0; n < DIGITS; n++) begin
            r[4*n +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic cyc(input logic inc, input logic rdy, input logic c);
        beat_t cur;
        @(negedge clk);
        inc_pulse = inc;
        upd_ready = rdy;
        clr = c;
        #1;
        cur.d = upd_digit;
        cur.i = upd_idx;
        cur.l = upd_last;
        if (stall_pend && !(upd_valid && cur == prev)) stall_bad++;
        if (upd_valid && rdy && !c) beats.push_back(cur);
        if (busy && !upd_valid) inc_cyc++;
        if (wrap) begin
            wrap_cnt++;
            if (!(busy && !upd_valid)) wrap_bad++;
        end
        stall_pend = upd_valid && !rdy && !c;
        prev = cur;
    endtask

    task automatic clear_obs();
        beats.delete();
        inc_cyc = 0;
        wrap_cnt = 0;
        wrap_bad = 0;
        stall_bad = 0;
    endtask

    task automatic drain(output bit ok);
        int quiet = 0;
        ok = 0;
        for (int n = 0; n < 600; n++) begin
            cyc(1'b0, 1'b1, 1'b0);
            quiet = busy ? 0 : quiet + 1;
            if (quiet >= 3) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic pulses(input int n);
        for (int p = 0; p < n; p++) begin
            cyc(1'b1, 1'b1, 1'b0);
            repeat (9) cyc(1'b0, 1'b1, 1'b0);
        end
    endtask

    task automatic do_clr();
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
        clear_obs();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        tests++;
        if ({bcd_value, busy, wrap, ovf, upd_valid, upd_digit, upd_idx, upd_last} !== '0) begin
            fails++;
            $display("FAIL reset: bcd=%h busy=%b wrap=%b ovf=%b valid=%b digit=%h idx=%0d last=%b, want all 0",
                     bcd_value, busy, wrap, ovf, upd_valid, upd_digit, upd_idx, upd_last);
        end
        @(negedge clk);
        rst_n = 1'b1;
        clear_obs();
    endtask

    task automatic test_single();
        bit ok;
        beat_t b, e;
        do_clr();
        cyc(1'b1, 1'b1, 1'b0);
        drain(ok);
        tests++;
        if (!ok || bcd_value !== 12'h001 || inc_cyc != 1) begin
            fails++;
            $display("FAIL single: ok=%0b bcd=%h inc_cycles=%0d, want bcd=001 inc_cycles=1", ok, bcd_value, inc_cyc);
        end
        tests++;
        if (beats.size() != 3) begin
            fails++;
            $display("FAIL single_beats: got %0d beats, want 3", beats.size());
        end
        for (int j = DIGITS - 1; j >= 0 && beats.size() > 0; j--) begin
            b = beats.pop_front();
            e.d = exp_digit(1, j);
            e.i = 3'(j);
            e.l = (j == 0);
            tests++;
            if (b !== e) begin
                fails++;
                $display("FAIL single_stream j=%0d: got d=%h i=%0d l=%b, want d=%h i=%0d l=%b", j, b.d, b.i, b.l, e.d, e.i, e.l);
            end
        end
    endtask

    task automatic test_carry();
        bit ok;
        beat_t b, e;
        do_clr();
        pulses(99);
        drain(ok);
        clear_obs();
        tests++;
        if (bcd_value !== 12'h099) begin
            fails++;
            $display("FAIL carry_preload: bcd=%h, want 099", bcd_value);
        end
        cyc(1'b1, 1'b1, 1'b0);
        drain(ok);
        tests++;
        if (!ok || bcd_value !== 12'h100 || inc_cyc != 3 || wrap_cnt != 0) begin
            fails++;
            $display("FAIL carry: bcd=%h inc_cycles=%0d wraps=%0d, want 100 3 0", bcd_value, inc_cyc, wrap_cnt);
        end
        for (int j = DIGITS - 1; j >= 0 && beats.size() > 0; j--) begin
            b = beats.pop_front();
            e.d = exp_digit(100, j);
            e.i = 3'(j);
            e.l = (j == 0);
            tests++;
            if (b !== e) begin
                fails++;
                $display("FAIL carry_stream j=%0d: got d=%h i=%0d, want d=%h i=%0d", j, b.d, b.i, e.d, e.i);
            end
        end
    endtask

    task automatic test_wrap();
        bit ok;
        beat_t b, e;
        do_clr();
        pulses(999);
        drain(ok);
        clear_obs();
        tests++;
        if (bcd_value !== 12'h999) begin
            fails++;
            $display("FAIL wrap_preload: bcd=%h, want 999", bcd_value);
        end
        cyc(1'b1, 1'b1, 1'b0);
        drain(ok);
        tests++;
        if (!ok || bcd_value !== 12'h000 || inc_cyc != 3 || wrap_cnt != 1 || wrap_bad != 0) begin
            fails++;
            $display("FAIL wrap: bcd=%h inc_cycles=%0d wraps=%0d misplaced=%0d, want 000 3 1 0",
                     bcd_value, inc_cyc, wrap_cnt, wrap_bad);
        end
        tests++;
        if (beats.size() != 3) begin
            fails++;
            $display("FAIL wrap_beats: got %0d, want 3", beats.size());
        end
        for (int j = DIGITS - 1; j >= 0 && beats.size() > 0; j--) begin
            b = beats.pop_front();
            e.d = exp_digit(0, j);
            e.i = 3'(j);
            e.l = (j == 0);
            tests++;
            if (b !== e) begin
                fails++;
                $display("FAIL wrap_stream j=%0d: got d=%h, want d=%h", j, b.d, e.d);
            end
        end
    endtask

    task automatic test_saturate();
        bit ok;
        beat_t b, e;
        int bad = 0;
        do_clr();
        repeat (20) cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        tests++;
        if (ovf !== 1'b1) begin
            fails++;
            $display("FAIL sat_ovf: ovf=%b, want 1", ovf);
        end
        drain(ok);
        tests++;
        if (!ok || beats.size() != 16 * DIGITS || bcd_value !== 12'h016) begin
            fails++;
            $display("FAIL sat_updates: beats=%0d bcd=%h, want %0d 016", beats.size(), bcd_value, 16 * DIGITS);
        end
        for (int v = 1; v <= 16 && beats.size() >= DIGITS; v++) begin
            for (int j = DIGITS - 1; j >= 0; j--) begin
                b = beats.pop_front();
                e.d = exp_digit(v, j);
                e.i = 3'(j);
                e.l = (j == 0);
                if (b !== e) bad++;
            end
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL sat_stream: %0d bad beats, want 0", bad);
        end
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
        tests++;
        if (ovf !== 1'b0) begin
            fails++;
            $display("FAIL sat_clr_ovf: ovf=%b, want 0", ovf);
        end
    endtask

    task automatic test_clr();
        bit ok;
        int n = 0;
        do_clr();
        pulses(5);
        drain(ok);
        clear_obs();
        cyc(1'b1, 1'b0, 1'b0);
        while (beats.size() == 0 && n < 100) begin
            cyc(1'b0, 1'(n % 2), 1'b0);
            n++;
        end
        cyc(1'b0, 1'b0, 1'b0);
        tests++;
        if (upd_valid !== 1'b1) begin
            fails++;
            $display("FAIL clr_setup: valid=%b, want 1 mid-stream", upd_valid);
        end
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
        tests++;
        if (upd_valid !== 1'b0 || bcd_value !== '0 || busy !== 1'b0 || ovf !== 1'b0) begin
            fails++;
            $display("FAIL clr_abort: valid=%b bcd=%h busy=%b ovf=%b, want 0 000 0 0", upd_valid, bcd_value, busy, ovf);
        end
        clear_obs();
        repeat (20) cyc(1'b0, 1'b1, 1'b0);
        tests++;
        if (beats.size() != 0 || inc_cyc != 0 || bcd_value !== '0) begin
            fails++;
            $display("FAIL clr_inc_ignored: beats=%0d inc_cycles=%0d bcd=%h, want 0 0 000", beats.size(), inc_cyc, bcd_value);
        end
    endtask

    task automatic test_random();
        bit ok;
        bit inc;
        int model = 0;
        int exp_q[$];
        int bad = 0;
        int v;
        beat_t b, e;
        do_clr();
        for (int c = 0; c < 4000; c++) begin
            inc = ($urandom_range(0, 15) == 0);
            cyc(inc, 1'($urandom % 2), 1'b0);
            if (inc) begin
                model = (model + 1) % 1000;
                exp_q.push_back(model);
            end
        end
        drain(ok);
        tests++;
        if (!ok || ovf !== 1'b0 || bcd_value !== to_bcd(model)) begin
            fails++;
            $display("FAIL rand_final: ok=%0b ovf=%b bcd=%h, want bcd=%h ovf=0", ok, ovf, bcd_value, to_bcd(model));
        end
        tests++;
        if (beats.size() != exp_q.size() * DIGITS) begin
            fails++;
            $display("FAIL rand_count: beats=%0d, want %0d", beats.size(), exp_q.size() * DIGITS);
        end
        while (exp_q.size() > 0 && beats.size() >= DIGITS) begin
            v = exp_q.pop_front();
            for (int j = DIGITS - 1; j >= 0; j--) begin
                b = beats.pop_front();
                e.d = exp_digit(v, j);
                e.i = 3'(j);
                e.l = (j == 0);
                if (b !== e) bad++;
            end
        end
        tests++;
        if (bad != 0 || stall_bad != 0) begin
            fails++;
            $display("FAIL rand_stream: bad beats=%0d unstable stalls=%0d, want 0 0", bad, stall_bad);
        end
    endtask

`ifdef BCD_SEQ_ASCII_EN
    task automatic test_ascii();
        bit ok;
        logic [7:0] want [3];
        beat_t b;
        want[0] = 8'h20;
        want[1] = 8'h20;
        want[2] = 8'h37;
        do_clr();
        pulses(6);
        drain(ok);
        clear_obs();
        cyc(1'b1, 1'b1, 1'b0);
        drain(ok);
        for (int n = 0; n < 3 && beats.size() > 0; n++) begin
            b = beats.pop_front();
            tests++;
            if (b.d !== want[n]) begin
                fails++;
                $display("FAIL ascii beat %0d: got %h, want %h", n, b.d, want[n]);
            end
        end
    endtask
`endif

    initial begin
        clear_obs();
        test_reset();
        test_single();
        test_carry();
        test_wrap();
        test_saturate();
        test_clr();
        test_random();
`ifdef BCD_SEQ_ASCII_EN
        test_ascii();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
